// File: rtl/alu_result_tx.sv
// Buffers ALU results ({carry, res}) in a small FIFO and serializes each one
// as a 3-byte, LSB-first frame on a registered valid/ready byte stream.
module alu_result_tx #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [17:0] res_q,
    input  logic        carry_q,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);

    // state  | meaning
    // IDLE   | nothing in flight, waiting for a FIFO entry
    // ST_B0  | presenting res[7:0]
    // ST_B1  | presenting res[15:8]
    // ST_B2  | presenting {5'b0, carry, res[17:16]}, out_last high
    typedef enum logic [1:0] {IDLE, ST_B0, ST_B1, ST_B2} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [18:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, hs;
    logic [18:0]   head;

    state_t      state, state_nx;
    logic [18:0] hold, hold_nx;
    logic [7:0]  byte_nx;
    logic        valid_nx, last_nx;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign res_ready = ~full;
    assign push      = res_valid & ~full;
    assign hs        = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign busy      = ~empty | (state != IDLE);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {carry_q, res_q};
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nx;
            hold      <= hold_nx;
            out_byte  <= byte_nx;
            out_valid <= valid_nx;
            out_last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold;
        byte_nx  = out_byte;
        valid_nx = out_valid;
        last_nx  = out_last;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    hold_nx  = head;
                    byte_nx  = head[7:0];
                    valid_nx = 1'b1;
                    last_nx  = 1'b0;
                    state_nx = ST_B0;
                end
            end
            ST_B0: begin
                if (hs) begin
                    byte_nx  = hold[15:8];
                    state_nx = ST_B1;
                end
            end
            ST_B1: begin
                if (hs) begin
                    byte_nx  = {5'b0, hold[18:16]};
                    last_nx  = 1'b1;
                    state_nx = ST_B2;
                end
            end
            ST_B2: begin
                // Reload straight from the FIFO so frames run back-to-back.
                if (hs && !empty) begin
                    pop      = 1'b1;
                    hold_nx  = head;
                    byte_nx  = head[7:0];
                    valid_nx = 1'b1;
                    last_nx  = 1'b0;
                    state_nx = ST_B0;
                end else if (hs) begin
                    byte_nx  = '0;
                    valid_nx = 1'b0;
                    last_nx  = 1'b0;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx: pushes are turned into expected bytes by
// the frame rule, and a negedge monitor checks every output handshake in order.
module tb_alu_result_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [17:0] res_q = '0;
    logic        carry_q = 1'b0;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;

    alu_result_tx #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_q     (res_q),
        .carry_q   (carry_q),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    int         cyc_n = 0;
    int         hs_total = 0;
    int         last_hs_cyc = 0;
    int         first_hs_cyc = 0;
    bit         first_seen = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference frame rule: three bytes, LSB first, last flag on the carry byte.
    function automatic void model_push(input logic [18:0] v);
        exp_q.push_back({1'b0, v[7:0]});
        exp_q.push_back({1'b0, v[15:8]});
        exp_q.push_back({1'b1, 5'b0, v[18:16]});
    endfunction

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            cyc_n++;
            if (res_valid && res_ready)
                model_push({carry_q, res_q});
            if (out_valid && out_ready) begin
                hs_total++;
                last_hs_cyc = cyc_n;
                if (!first_seen) begin
                    first_seen   = 1'b1;
                    first_hs_cyc = cyc_n;
                end
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got %0h expected none", {out_last, out_byte});
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_byte", {23'b0, out_last, out_byte}, {23'b0, e});
                end
            end
        end
    end

    task automatic push_one(input logic [18:0] v);
        res_valid = 1'b1;
        {carry_q, res_q} = v;
        cyc();
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cyc();
            k++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [18:0] v [4];
        logic [18:0] b_val;
        int          pushed;
        int          guard;
        int          h0;
        logic        rdy;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_last",  {31'b0, out_last},  32'd0);
        chk("rst_out_byte",  {24'b0, out_byte},  32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_res_ready", {31'b0, res_ready}, 32'd1);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single frame
        out_ready = 1'b1;
        push_one({1'b1, 18'h2A5C3});
        chk("sf_latency", {31'b0, out_valid}, 32'd0);
        cyc();
        chk("sf_b0", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b0, 8'hC3});
        cyc();
        chk("sf_b1", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b0, 8'hA5});
        cyc();
        chk("sf_b2", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b1, 8'h06});
        cyc();
        chk("sf_busy_done", {30'b0, busy, out_valid}, 32'd0);

        // Downstream stall
        out_ready = 1'b0;
        push_one({1'b0, 18'h3FFFF});
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {23'b0, out_valid, out_byte}, {23'b0, 1'b1, 8'hFF});
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        chk("stall_b1", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b0, 8'hFF});
        cyc();
        chk("stall_b2", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b1, 8'h03});
        wait_idle(20);

        // Fill / backpressure
        v[0] = 19'h1_2345; v[1] = 19'h0_6789; v[2] = 19'h5_ABCD; v[3] = 19'h7_0F1E;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_one(v[i]);
        chk("fill_full", {31'b0, res_ready}, 32'd0);
        res_valid = 1'b1;
        {carry_q, res_q} = v[3];
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fill_blocked", {31'b0, res_ready}, 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("fill_no_bubble", {31'b0, out_valid}, 32'd1);
            if (k < 3)
                chk("fill_ready_low", {31'b0, res_ready}, 32'd0);
            if (k == 3)
                chk("fill_ready_rise", {31'b0, res_ready}, 32'd1);
            cyc();
            if (k == 3)
                res_valid = 1'b0;
        end
        chk("fill_end", {31'b0, out_valid}, 32'd0);
        wait_idle(20);

        // Simultaneous push/pop at B2 with one entry queued
        out_ready = 1'b1;
        b_val = 19'h2_4C7D;
        push_one(19'h3_1111);
        push_one(b_val);
        cyc();
        cyc();
        push_one(19'h0_2222);
        chk("simul_next", {23'b0, out_valid, out_byte}, {23'b0, 1'b1, b_val[7:0]});
        chk("simul_count1", {31'b0, res_ready}, 32'd1);
        push_one(19'h6_3333);
        chk("simul_count2", {31'b0, res_ready}, 32'd0);
        wait_idle(40);

        // Pointer wrap over 10 back-to-back results
        h0 = hs_total;
        first_seen = 1'b0;
        pushed = 0;
        guard = 0;
        while (pushed < 10 && guard < 200) begin
            res_valid = 1'b1;
            {carry_q, res_q} = 19'($urandom);
            rdy = res_ready;
            cyc();
            if (rdy)
                pushed++;
            guard++;
        end
        res_valid = 1'b0;
        chk("wrap_pushed", pushed, 10);
        wait_idle(100);
        chk("wrap_bytes", hs_total - h0, 30);
        chk("wrap_no_bubble", last_hs_cyc - first_hs_cyc, 29);

        // Reset mid-frame
        out_ready = 1'b0;
        push_one(19'h1_0A0B);
        push_one(19'h2_0C0D);
        push_one(19'h3_0E0F);
        out_ready = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'b0, busy},      32'd0);
        chk("mid_rst_ready", {31'b0, res_ready}, 32'd1);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        push_one({1'b0, 18'h00001});
        cyc();
        chk("post_rst_b0", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b0, 8'h01});
        cyc();
        chk("post_rst_b1", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b0, 8'h00});
        cyc();
        chk("post_rst_b2", {22'b0, out_valid, out_last, out_byte}, {22'b0, 1'b1, 1'b1, 8'h00});
        wait_idle(20);

        // Random soak
        for (int i = 0; i < 2000; i++) begin
            res_valid = 1'($urandom_range(0, 1));
            {carry_q, res_q} = 19'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        res_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle(200);
        chk("soak_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Transmit end of the ALU result handshake. Accepts 18-bit results plus carry from the ALU stage over `res_valid`/`res_ready`, buffers them in a small FIFO, and serializes each result as a 3-byte frame onto an 8-bit output stream with its own valid/ready handshake. It sits between the ALU stage and the chip's 8-bit output pins, and is the only consumer of the ALU result port.

## Interface

**Parameters**

- `FIFO_DEPTH`, default 2: result entries buffered ahead of the serializer. Must be a power of 2 and at least 2.

**Ports**

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `res_valid` in 1: ALU result valid.
- `res_ready` out 1: block can accept a result. Equals `~fifo_full`.
- `res_q` in 18: ALU result.
- `carry_q` in 1: ALU carry/borrow.
- `out_byte` out 8: serialized byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: downstream accepts the byte.
- `out_last` out 1: high on the final byte of a frame.
- `busy` out 1: FIFO is non-empty or the FSM is not in IDLE.

## Operation

- **Push:** occurs at a rising edge where `res_valid & res_ready`. `{carry_q, res_q}` (19 bits) is written at the FIFO tail.
- **No push when full:** `res_ready` is low while full, so a write while full cannot happen. There is no bypass path around the FIFO.
- **Frame format, LSB first:**
  - B0 = `res[7:0]`
  - B1 = `res[15:8]`
  - B2 = `{5'b0, carry, res[17:16]}`
- **Output registers:** `out_last` is high only with B2. `out_byte`, `out_valid` and `out_last` are all registered.
- **FSM states:** IDLE, B0, B1, B2. The FSM owns a 19-bit holding register.
  - IDLE: if the FIFO is non-empty, pop the head into the holding register and go to B0. Otherwise stay.
  - B0 -> B1, and B1 -> B2: advance on an `out_valid & out_ready` handshake.
  - B2 on handshake: if the FIFO is non-empty, pop the head and go to B0 with no bubble. Otherwise go to IDLE.
- **Holding output:** with no handshake, the state, `out_byte` and `out_last` hold their values. `out_valid` stays high in B0–B2 and must not drop until the handshake.
- **Simultaneous push and pop:** both happen in the same cycle. The count is unchanged and pointers wrap modulo `FIFO_DEPTH`. A push into an empty FIFO is not visible to a pop in that same cycle.
- **Total capacity:** `FIFO_DEPTH` + 1 results (FIFO plus the holding register).
- **`out_ready` high while `out_valid` low:** ignored.

## Timing

- **Reset values:** while `rst_n` is low, all of the following are cleared, asynchronously:
  - FIFO pointers and count are 0.
  - FSM is in IDLE.
  - `out_valid`, `out_last` and `out_byte` are 0.
  - `busy` is 0.
  - `res_ready` is 1, because the FIFO is empty.
- **Latency:** a push at edge N into an empty, idle block is popped at edge N+1. `out_valid` is high with B0 after edge N+1.
- **Throughput:** with `out_ready` held high, one byte per cycle. A frame takes 3 cycles, and frames run back-to-back with no idle cycle while the FIFO is non-empty.
- **`res_ready` timing:** combinational from the registered count only. It has no combinational path from `out_ready` or `res_valid`.
- **`res_ready` rises after a pop:** when a full FIFO is popped at edge M, `res_ready` is high after edge M.
- **Reset mid-frame:** asserting `rst_n` low mid-frame discards the frame and all buffered entries. No partial frame is resumed after reset.

## Test plan

- **Single frame:** reset, then push `res_q=18'h2A5C3`, `carry_q=1`, with `out_ready=1`. Required response:
  - Bytes 8'hC3, 8'hA5, 8'h06 on three consecutive cycles.
  - `out_last` high only on 8'h06.
  - `out_valid` first high 1 cycle after the push edge.
  - `busy` low after the final handshake.
- **Downstream stall:** push `18'h3FFFF`, `carry=0`, with `out_ready=0` for 5 cycles and then 1. Required response:
  - `out_byte` held at 8'hFF with `out_valid` high through the stall.
  - Then 8'hFF, 8'h03 with `out_last`.
- **Fill / backpressure:** `FIFO_DEPTH=2`, `out_ready=0`, push 4 distinct results. Required response:
  - The 1st result is loaded into the holding register.
  - The 2nd and 3rd fill the FIFO.
  - `res_ready` drops; the 4th is held by the source.
  - Release `out_ready`: `res_ready` rises after the first frame's head pop. All 4 frames appear in order, 12 bytes with no bubbles.
- **Simultaneous push/pop:** FIFO has 1 entry and the FSM is finishing B2 while a new push occurs. Required response:
  - Count stays 1 and the next frame starts immediately.
  - Pointer wrap verified over 10 results.
- **Reset mid-frame:** pull `rst_n` low after B1's handshake with 2 entries queued. Required response:
  - `out_valid` and `busy` are 0 immediately, and `res_ready` is 1.
  - After release, a fresh push `18'h00001` produces 8'h01, 8'h00, 8'h00.
- **Random soak:** random `res_valid`/`out_ready` over 2000 cycles. Required response: a scoreboard reassembles the frames and matches every pushed `{carry, res}` exactly, in order, with no loss or duplication.
